// File: rtl/lfsr_noise_pkg.sv
// lfsr_noise_pkg
// Shared definitions for the LFSR noise generator.
//   - Default parameter constants for lfsr_noise_gen.
//   - tap_mask(width): maximal-length Fibonacci tap mask for widths 8..32.
//     Bit i set means state bit i feeds the XOR. Bit 0 is always set, which
//     is what makes the reverse step possible.
//   - rotl(value, amount, width): rotate left inside a width-bit field.
//   - step_dir_e: direction encoding of the dir input.
// No ports. The package has no configuration macros.
package lfsr_noise_pkg;

  localparam int DEF_WIDTH    = 24;
  localparam int DEF_CHANNELS = 4;
  localparam int DEF_OUT_BITS = 8;
  localparam int DEF_STRIDE   = 5;
  localparam int MAX_WIDTH    = 32;

  typedef enum logic {
    STEP_REV = 1'b0,
    STEP_FWD = 1'b1
  } step_dir_e;

  // Each mask is a primitive polynomial with the x^width term dropped.
  // The low bits give the characteristic polynomial x^W + sum(T[i] x^i).
  function automatic logic [MAX_WIDTH-1:0] tap_mask(input int width);
    logic [MAX_WIDTH-1:0] mask;
    case (width)
      8:       mask = 32'h0000_001D;
      9:       mask = 32'h0000_0021;
      10:      mask = 32'h0000_0081;
      11:      mask = 32'h0000_0201;
      12:      mask = 32'h0000_0C11;
      13:      mask = 32'h0000_1901;
      14:      mask = 32'h0000_3005;
      15:      mask = 32'h0000_4001;
      16:      mask = 32'h0000_A011;
      17:      mask = 32'h0000_4001;
      18:      mask = 32'h0000_0801;
      19:      mask = 32'h0006_4001;
      20:      mask = 32'h0002_0001;
      21:      mask = 32'h0008_0001;
      22:      mask = 32'h0020_0001;
      23:      mask = 32'h0004_0001;
      24:      mask = 32'h00C2_0001;
      25:      mask = 32'h0040_0001;
      26:      mask = 32'h0000_0047;
      27:      mask = 32'h0000_0027;
      28:      mask = 32'h0200_0001;
      29:      mask = 32'h0800_0001;
      30:      mask = 32'h0000_0053;
      31:      mask = 32'h1000_0001;
      32:      mask = 32'h0040_0007;
      default: mask = 32'h0000_0000;
    endcase
    return mask;
  endfunction

  // The value must already fit in width bits. Bits above width come back as
  // zero, so the caller can cast the result down to the field width.
  function automatic logic [MAX_WIDTH-1:0] rotl(input logic [MAX_WIDTH-1:0] value,
                                                input int                   amount,
                                                input int                   width);
    logic [MAX_WIDTH-1:0] field_mask;
    logic [MAX_WIDTH-1:0] result;
    int                   amt;
    amt        = (width > 0) ? (amount % width) : 0;
    field_mask = (width >= MAX_WIDTH) ? '1 : ((32'd1 << width) - 32'd1);
    result     = ((value << amt) | (value >> (width - amt))) & field_mask;
    return result;
  endfunction

endpackage

// File: rtl/lfsr_noise_core.sv
// lfsr_noise_core
// One noise channel. It holds a Fibonacci LFSR state and can step it forward
// or in reverse. A zero state is recovered to 1 on the next step. The low
// OUT_BITS of the post-step state are offered as the channel sample.
//
// Optional feature (macro LFSR_NOISE_WRAP_EN):
//   The channel remembers its reset/loaded seed. wrap_hit flags a step whose
//   new state equals that seed. Without the macro there is no seed register
//   and no wrap_hit port.
//
// Parameters: WIDTH    - state width (8..32)
//             OUT_BITS - sample width (<= WIDTH)
//             ROT      - seed rotation for this channel, already reduced
//                        modulo WIDTH
// Ports: clk, reset (async, active-high)
//        load     - replace the state with the rotated seed
//        seed     - base seed shared by all channels
//        step     - advance the state this cycle
//        dir      - 1 forward, 0 reverse
//        sample   - low OUT_BITS of the state the pending step produces
//        wrap_hit - (macro only) pending step lands back on the stored seed
module lfsr_noise_core
  import lfsr_noise_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int OUT_BITS = DEF_OUT_BITS,
  parameter int ROT      = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [WIDTH-1:0]    seed,
  input  logic                step,
  input  logic                dir,
  output logic [OUT_BITS-1:0] sample
`ifdef LFSR_NOISE_WRAP_EN
  ,
  output logic                wrap_hit
`endif
);

  localparam logic [WIDTH-1:0] TAPS        = WIDTH'(tap_mask(WIDTH));
  localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);
  localparam logic [WIDTH-1:0] RESET_STATE = WIDTH'(rotl(32'd1, ROT, WIDTH));

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] next_state;
  logic [WIDTH-1:0] fwd_state;
  logic [WIDTH-1:0] rev_state;
  logic [WIDTH-1:0] load_state;

  // The reverse step undoes the forward shift. The old bit 0 is recovered
  // from the feedback bit, because T[0] = 1 means bit 0 always takes part in
  // the XOR.
  always_comb begin
    fwd_state  = {^(state & TAPS), state[WIDTH-1:1]};
    rev_state  = {state[WIDTH-2:0],
                  state[WIDTH-1] ^ (^(state[WIDTH-2:0] & TAPS[WIDTH-1:1]))};
    next_state = rev_state;
    if (state == '0) begin
      next_state = ONE;
    end else if (step_dir_e'(dir) == STEP_FWD) begin
      next_state = fwd_state;
    end
    load_state = WIDTH'(rotl(MAX_WIDTH'(seed), ROT, WIDTH));
    if (load_state == '0) begin
      load_state = ONE;
    end
  end

  assign sample = next_state[OUT_BITS-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RESET_STATE;
    end else if (load) begin
      state <= load_state;
    end else if (step) begin
      state <= next_state;
    end
  end

`ifdef LFSR_NOISE_WRAP_EN
  logic [WIDTH-1:0] seed_q;

  // The stored seed follows the same reset and load values as the state. A
  // full period therefore ends exactly when the state returns to it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seed_q <= RESET_STATE;
    end else if (load) begin
      seed_q <= load_state;
    end
  end

  assign wrap_hit = (next_state == seed_q);
`endif

endmodule

// File: rtl/lfsr_noise_gen.sv
// lfsr_noise_gen
// Multi-channel LFSR noise source with a valid/ready output. CHANNELS
// independent LFSR cores step together. The output register presents one
// OUT_BITS slice per channel and holds the sample until the consumer takes it.
//
// Optional feature (macro LFSR_NOISE_WRAP_EN):
//   wrap[k] rises with the sample on which channel k returns to its seed.
//   Without the macro, wrap is tied to 0.
//
// Parameters: WIDTH (8..32), CHANNELS, OUT_BITS (<= WIDTH), STRIDE
// Ports: clk, reset (async, active-high)
//        load      - seed load strobe; takes priority over stepping
//        seed      - base seed; channel k gets rotl(seed, k*STRIDE mod WIDTH)
//        enable    - permit stepping
//        dir       - 1 forward, 0 reverse
//        out_ready - consumer accepts out_data
//        out_valid - out_data holds a fresh sample
//        out_data  - channel k in [k*OUT_BITS +: OUT_BITS]
//        wrap      - per-channel period-complete flag, qualified by out_valid
module lfsr_noise_gen
  import lfsr_noise_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int OUT_BITS = DEF_OUT_BITS,
  parameter int STRIDE   = DEF_STRIDE
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load,
  input  logic [WIDTH-1:0]             seed,
  input  logic                         enable,
  input  logic                         dir,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [CHANNELS*OUT_BITS-1:0] out_data,
  output logic [CHANNELS-1:0]          wrap
);

  logic                         step;
  logic [CHANNELS*OUT_BITS-1:0] sample_all;
`ifdef LFSR_NOISE_WRAP_EN
  logic [CHANNELS-1:0]          wrap_hit;
`endif

  // A step is allowed only when the output register is free. The register
  // is free when it holds nothing, or when its sample is being taken this
  // cycle. This gives back-to-back samples while out_ready stays high.
  assign step = enable & ~load & (~out_valid | out_ready);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    lfsr_noise_core #(
      .WIDTH   (WIDTH),
      .OUT_BITS(OUT_BITS),
      .ROT     ((k * STRIDE) % WIDTH)
    ) u_core (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .seed    (seed),
      .step    (step),
      .dir     (dir),
      .sample  (sample_all[k*OUT_BITS +: OUT_BITS])
`ifdef LFSR_NOISE_WRAP_EN
      ,
      .wrap_hit(wrap_hit[k])
`endif
    );
  end

  // Output register. A load drops any pending sample. An accepted sample
  // with no replacement empties the register. A stalled sample keeps its
  // data and flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b0;
    end else if (step) begin
      out_valid <= 1'b1;
      out_data  <= sample_all;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef LFSR_NOISE_WRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrap <= '0;
    end else if (load) begin
      wrap <= '0;
    end else if (step) begin
      wrap <= wrap_hit;
    end
  end
`else
  assign wrap = '0;
`endif

endmodule

// File: tb/tb_lfsr_noise_gen.sv
// tb_lfsr_noise_gen
// Directed bench for lfsr_noise_gen. It uses two instances: the default
// 24-bit, 4-channel build, and an 8-bit, single-channel build for the
// full-period run. Expected values come from hand-derived constants and a
// small independent LFSR model built on x^24+x^23+x^22+x^17+1.
// Wrap expectations follow LFSR_NOISE_WRAP_EN.
module tb_lfsr_noise_gen;

  localparam logic [23:0] T24 = 24'hC20001;
`ifdef LFSR_NOISE_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  logic        load, enable, dir, out_ready, out_valid;
  logic [23:0] seed;
  logic [31:0] out_data;
  logic [3:0]  wrap;

  logic        load8, enable8, dir8, ready8, valid8;
  logic [7:0]  seed8, data8;
  logic [0:0]  wrap8;

  int tests = 0;
  int fails = 0;

  logic [23:0] exp_state [4];
  logic [31:0] fwd_rec [1000];
  logic [31:0] rev_rec [1000];

  always #5 clk = ~clk;

  lfsr_noise_gen #(
    .WIDTH(24), .CHANNELS(4), .OUT_BITS(8), .STRIDE(5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .seed     (seed),
    .enable   (enable),
    .dir      (dir),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .wrap     (wrap)
  );

  lfsr_noise_gen #(
    .WIDTH(8), .CHANNELS(1), .OUT_BITS(8), .STRIDE(5)
  ) dut8 (
    .clk      (clk),
    .reset    (reset),
    .load     (load8),
    .seed     (seed8),
    .enable   (enable8),
    .dir      (dir8),
    .out_ready(ready8),
    .out_valid(valid8),
    .out_data (data8),
    .wrap     (wrap8)
  );

  function automatic logic [23:0] rotl24(input logic [23:0] v, input int n);
    logic [47:0] t;
    t = {v, v} << n;
    return t[47:24];
  endfunction

  function automatic logic [23:0] fwd24(input logic [23:0] s);
    logic [23:0] t;
    t = T24;
    if (s == 24'h0) return 24'h1;
    return {^(s & t), s[23:1]};
  endfunction

  function automatic logic [23:0] rev24(input logic [23:0] s);
    logic [23:0] t;
    t = T24;
    if (s == 24'h0) return 24'h1;
    return {s[22:0], s[23] ^ (^(s[22:0] & t[23:1]))};
  endfunction

  function automatic logic [31:0] model_out();
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[k*8 +: 8] = exp_state[k][7:0];
    return r;
  endfunction

  function automatic logic [23:0] dut_state(input int k);
    case (k)
      0:       return dut.g_chan[0].u_core.state;
      1:       return dut.g_chan[1].u_core.state;
      2:       return dut.g_chan[2].u_core.state;
      default: return dut.g_chan[3].u_core.state;
    endcase
  endfunction

  task automatic model_load(input logic [23:0] s);
    for (int k = 0; k < 4; k++) begin
      exp_state[k] = rotl24(s, (k * 5) % 24);
      if (exp_state[k] == 24'h0) exp_state[k] = 24'h1;
    end
  endtask

  task automatic model_step(input logic d);
    for (int k = 0; k < 4; k++) exp_state[k] = d ? fwd24(exp_state[k]) : rev24(exp_state[k]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic l, input logic [23:0] s, input logic en,
                               input logic d, input logic rdy);
    load      = l;
    seed      = s;
    enable    = en;
    dir       = d;
    out_ready = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    int          bad_valid, bad_model, bad_rev, zero_seen, first_one, first_wrap;
    logic [31:0] held;

    applyStimulus(1'b0, 24'h0, 1'b0, 1'b1, 1'b1);
    load8 = 1'b0; seed8 = 8'h0; enable8 = 1'b0; dir8 = 1'b1; ready8 = 1'b1;
    reset = 1'b1;
    #12;

    // Reset values.
    checkOutput("reset_valid", 32'(out_valid), 32'h0);
    checkOutput("reset_data", out_data, 32'h0);
    checkOutput("reset_wrap", 32'(wrap), 32'h0);
    checkOutput("reset_state0", 32'(dut_state(0)), 32'h000001);
    checkOutput("reset_state1", 32'(dut_state(1)), 32'h000020);
    checkOutput("reset_state2", 32'(dut_state(2)), 32'h000400);
    checkOutput("reset_state3", 32'(dut_state(3)), 32'h008000);
    checkOutput("reset_valid8", 32'(valid8), 32'h0);
    reset = 1'b0;
    tick();

    // Zero seed recovers to 1 on every channel.
    applyStimulus(1'b1, 24'h000000, 1'b0, 1'b1, 1'b1);
    tick();
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("zero_seed_state%0d", k), 32'(dut_state(k)), 32'h1);
    checkOutput("zero_seed_valid", 32'(out_valid), 32'h0);

    applyStimulus(1'b1, 24'h000001, 1'b0, 1'b1, 1'b1);
    tick();
    model_load(24'h000001);
    checkOutput("seed1_state1", 32'(dut_state(1)), 32'h000020);
    checkOutput("seed1_state3", 32'(dut_state(3)), 32'h008000);

    // First step: 0x20 -> 0x10 on channel 1, and the others give zero low bytes.
    applyStimulus(1'b0, 24'h000001, 1'b1, 1'b1, 1'b1);
    tick();
    model_step(1'b1);
    checkOutput("first_valid", 32'(out_valid), 32'h1);
    checkOutput("first_data", out_data, 32'h0000_1000);
    checkOutput("first_data_model", out_data, model_out());

    // Load and step in the same cycle: the load wins.
    applyStimulus(1'b1, 24'h5A5A5A, 1'b1, 1'b1, 1'b1);
    tick();
    model_load(24'h5A5A5A);
    checkOutput("load_wins_valid", 32'(out_valid), 32'h0);
    checkOutput("load_wins_wrap", 32'(wrap), 32'h0);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("load_wins_state%0d", k), 32'(dut_state(k)), 32'(exp_state[k]));

    // Reversibility: 1000 forward steps, then 1000 reverse steps.
    applyStimulus(1'b1, 24'hACE135, 1'b0, 1'b1, 1'b1);
    tick();
    model_load(24'hACE135);
    bad_valid = 0; bad_model = 0; bad_rev = 0;
    applyStimulus(1'b0, 24'hACE135, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      tick();
      model_step(1'b1);
      fwd_rec[i] = out_data;
      if (out_valid !== 1'b1) bad_valid++;
      if (out_data !== model_out()) bad_model++;
    end
    applyStimulus(1'b0, 24'hACE135, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      tick();
      model_step(1'b0);
      rev_rec[i] = out_data;
      if (out_valid !== 1'b1) bad_valid++;
      if (out_data !== model_out()) bad_model++;
    end
    applyStimulus(1'b0, 24'hACE135, 1'b0, 1'b1, 1'b1);
    for (int j = 0; j < 999; j++)
      if (rev_rec[j] !== fwd_rec[998 - j]) bad_rev++;
    checkOutput("stream_valid_gaps", 32'(bad_valid), 32'h0);
    checkOutput("stream_model_errors", 32'(bad_model), 32'h0);
    checkOutput("reverse_order_errors", 32'(bad_rev), 32'h0);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("reverse_final_state%0d", k), 32'(dut_state(k)),
                  32'(rotl24(24'hACE135, (k * 5) % 24)));
    checkOutput("reverse_wrap", 32'(wrap), WRAP_EN ? 32'hF : 32'h0);

    // Backpressure: the sample holds for 5 stalled cycles, then exactly one step.
    applyStimulus(1'b0, 24'hACE135, 1'b1, 1'b1, 1'b1);
    tick();
    model_step(1'b1);
    held = out_data;
    checkOutput("bp_first_data", held, model_out());
    applyStimulus(1'b0, 24'hACE135, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("bp_hold_valid%0d", i), 32'(out_valid), 32'h1);
      checkOutput($sformatf("bp_hold_data%0d", i), out_data, held);
      checkOutput($sformatf("bp_hold_state%0d", i), 32'(dut_state(0)), 32'(exp_state[0]));
    end
    applyStimulus(1'b0, 24'hACE135, 1'b1, 1'b1, 1'b1);
    tick();
    model_step(1'b1);
    checkOutput("bp_resume_valid", 32'(out_valid), 32'h1);
    checkOutput("bp_resume_data", out_data, model_out());
    applyStimulus(1'b0, 24'hACE135, 1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("bp_drain_valid", 32'(out_valid), 32'h0);
    checkOutput("bp_drain_state", 32'(dut_state(0)), 32'(exp_state[0]));

    // Reset in mid-cycle while a sample waits unaccepted.
    applyStimulus(1'b0, 24'hACE135, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("pre_reset_valid", 32'(out_valid), 32'h1);
    applyStimulus(1'b0, 24'hACE135, 1'b0, 1'b1, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("mid_reset_valid", 32'(out_valid), 32'h0);
    checkOutput("mid_reset_data", out_data, 32'h0);
    checkOutput("mid_reset_wrap", 32'(wrap), 32'h0);
    checkOutput("mid_reset_state0", 32'(dut_state(0)), 32'h000001);
    checkOutput("mid_reset_state1", 32'(dut_state(1)), 32'h000020);
    checkOutput("mid_reset_state2", 32'(dut_state(2)), 32'h000400);
    checkOutput("mid_reset_state3", 32'(dut_state(3)), 32'h008000);
    #2;
    reset = 1'b0;
    tick();

    // Full period on the 8-bit instance.
    load8 = 1'b1; seed8 = 8'h01; enable8 = 1'b0;
    tick();
    checkOutput("p8_load_valid", 32'(valid8), 32'h0);
    checkOutput("p8_load_state", 32'(dut8.g_chan[0].u_core.state), 32'h01);
    load8 = 1'b0; enable8 = 1'b1; dir8 = 1'b1; ready8 = 1'b1;
    bad_valid = 0; zero_seen = 0; first_one = 0; first_wrap = 0;
    for (int n = 1; n <= 255; n++) begin
      tick();
      if (valid8 !== 1'b1) bad_valid++;
      if (data8 == 8'h00 || dut8.g_chan[0].u_core.state == 8'h00) zero_seen++;
      if (data8 == 8'h01 && first_one == 0) first_one = n;
      if (wrap8[0] === 1'b1 && first_wrap == 0) first_wrap = n;
    end
    enable8 = 1'b0;
    checkOutput("p8_valid_gaps", 32'(bad_valid), 32'h0);
    checkOutput("p8_zero_seen", 32'(zero_seen), 32'h0);
    checkOutput("p8_period", 32'(first_one), 32'd255);
    checkOutput("p8_first_wrap", 32'(first_wrap), WRAP_EN ? 32'd255 : 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
